// File: rtl/ucpd_pkg.sv
// Shared types and default lengths for the UCPD transmit framer.
package ucpd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_SOP  = 3'd2,
      ST_DATA = 3'd3,
      ST_CRC  = 3'd4,
      ST_EOP  = 3'd5,
      ST_BIST = 3'd6,
      ST_WAIT = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      MODE_PKT  = 2'd0,
      MODE_HRST = 2'd1,
      MODE_CRST = 2'd2,
      MODE_BIST = 2'd3
   } tx_mode_e;

   localparam int unsigned DEF_PRE_BITS  = 32'd64;
   localparam int unsigned DEF_SOP_BITS  = 32'd20;
   localparam int unsigned DEF_CRC_BITS  = 32'd40;
   localparam int unsigned DEF_EOP_BITS  = 32'd5;
   localparam int unsigned DEF_BIST_BITS = 32'd4096;
   localparam int unsigned DEF_IFG_BITS  = 32'd25;
   localparam int unsigned DEF_PSZ_W     = 32'd10;

   // One payload byte after 4b5b is two 5-bit symbols.
   localparam int unsigned DATA_SYM_BITS = 32'd10;
   // Phase bit counter width, wide enough for the BIST carrier.
   localparam int unsigned BCNT_W        = 32'd13;

endpackage

// File: rtl/ucpd_phase_cnt.sv
// Bit counter for the current framer phase: counts bit ticks, flags the
// terminal count and the last bit of every 5-bit symbol.
module ucpd_phase_cnt
   import ucpd_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              tick_i,
   input  logic [BCNT_W-1:0] last_i,
   output logic              tc_o,
   output logic              edge5_o
);

   logic [BCNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]        sym_q, sym_d;

   // Next count: clear wins over tick, otherwise hold between ticks.
   always_comb begin
      cnt_d = cnt_q;
      sym_d = sym_q;
      if (clr_i) begin
         cnt_d = {BCNT_W{1'b0}};
         sym_d = 3'd0;
      end else if (tick_i) begin
         cnt_d = cnt_q + BCNT_W'(1);
         sym_d = (sym_q == 3'd4) ? 3'd0 : (sym_q + 3'd1);
      end else begin
         cnt_d = cnt_q;
         sym_d = sym_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {BCNT_W{1'b0}};
         sym_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
         sym_q <= sym_d;
      end
   end

   assign tc_o    = (cnt_q == last_i);
   assign edge5_o = (sym_q == 3'd4);

endmodule

// File: rtl/apb_ucpd_tx_framer.sv
// USB-PD transmit framer: sequences preamble, ordered set, payload, CRC,
// EOP and inter-frame gap on bit ticks, with underrun / hard-reset abort.
module apb_ucpd_tx_framer
   import ucpd_pkg::*;
#(
   parameter int unsigned PRE_BITS  = DEF_PRE_BITS,
   parameter int unsigned SOP_BITS  = DEF_SOP_BITS,
   parameter int unsigned CRC_BITS  = DEF_CRC_BITS,
   parameter int unsigned EOP_BITS  = DEF_EOP_BITS,
   parameter int unsigned BIST_BITS = DEF_BIST_BITS,
   parameter int unsigned IFG_BITS  = DEF_IFG_BITS,
   parameter int unsigned PSZ_W     = DEF_PSZ_W
) (
   input  logic             ic_clk,
   input  logic             ic_rst_n,
   input  logic             ucpden,
   input  logic             bit_tick,
   input  logic             tx_start,
   input  logic [1:0]       tx_mode,
   input  logic [PSZ_W-1:0] tx_paysize,
   input  logic             transwin_en,
   input  logic             hrst_req,
   input  logic             byte_vld,
   output logic             byte_req,
   output logic             pre_en,
   output logic             sop_en,
   output logic             data_en,
   output logic             crc_en,
   output logic             eop_en,
   output logic             bist_en,
   output logic             wait_en,
   output logic             cc_oen,
   output logic             tx_done,
   output logic             tx_abort,
   output logic             tx_und,
   output logic             start_drop
);

   state_e            state_q, state_d;
   tx_mode_e          mode_q, mode_d;
   logic [PSZ_W-1:0]  last_q, last_d;       // index of the final payload byte
   logic [PSZ_W-1:0]  bytecnt_q, bytecnt_d;
   logic              abort_q, abort_d;     // underrun seen, abort pending
   logic [BCNT_W-1:0] len_m1_s;
   logic              tc_s, edge5_s, cnt_clr_s, end_s, abort_edge_s;

   function automatic logic [BCNT_W-1:0] len_m1(input int unsigned bits);
      return BCNT_W'(bits - 32'd1);
   endfunction

   ucpd_phase_cnt u_phase_cnt (
      .clk_i   (ic_clk),
      .rst_ni  (ic_rst_n),
      .clr_i   (cnt_clr_s),
      .tick_i  (bit_tick),
      .last_i  (len_m1_s),
      .tc_o    (tc_s),
      .edge5_o (edge5_s)
   );

   // Terminal count of the current phase (DATA terminates per byte).
   always_comb begin
      len_m1_s = {BCNT_W{1'b0}};
      case (state_q)
         ST_PRE:  len_m1_s = len_m1(PRE_BITS);
         ST_SOP:  len_m1_s = len_m1(SOP_BITS);
         ST_DATA: len_m1_s = len_m1(DATA_SYM_BITS);
         ST_CRC:  len_m1_s = len_m1(CRC_BITS);
         ST_EOP:  len_m1_s = len_m1(EOP_BITS);
         ST_BIST: len_m1_s = len_m1(BIST_BITS);
         ST_WAIT: len_m1_s = len_m1(IFG_BITS);
         default: len_m1_s = {BCNT_W{1'b0}};
      endcase
   end

   assign end_s        = bit_tick & tc_s;
   assign abort_edge_s = bit_tick & edge5_s & (abort_q | hrst_req);

   // Next-state logic and single-cycle event pulses.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      last_d     = last_q;
      bytecnt_d  = bytecnt_q;
      abort_d    = abort_q;
      cnt_clr_s  = 1'b0;
      byte_req   = 1'b0;
      tx_done    = 1'b0;
      tx_abort   = 1'b0;
      tx_und     = 1'b0;
      start_drop = 1'b0;
      if (!ucpden) begin
         state_d   = ST_IDLE;
         mode_d    = MODE_PKT;
         last_d    = PSZ_W'(0);
         bytecnt_d = PSZ_W'(0);
         abort_d   = 1'b0;
         cnt_clr_s = 1'b1;
      end else begin
         start_drop = tx_start & ((state_q != ST_IDLE) | ~transwin_en);
         case (state_q)
            ST_IDLE: begin
               cnt_clr_s = 1'b1;
               if (tx_start & transwin_en) begin
                  state_d   = ST_PRE;
                  mode_d    = tx_mode_e'(tx_mode);
                  // A zero byte count still sends one byte.
                  last_d    = (tx_paysize == PSZ_W'(0)) ? PSZ_W'(0) : (tx_paysize - PSZ_W'(1));
                  bytecnt_d = PSZ_W'(0);
                  abort_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PRE: begin
               cnt_clr_s = end_s;
               state_d   = end_s ? ST_SOP : ST_PRE;
            end
            ST_SOP: begin
               cnt_clr_s = end_s;
               if (end_s) begin
                  case (mode_q)
                     MODE_HRST: begin state_d = ST_IDLE; tx_done = 1'b1; end
                     MODE_CRST: begin state_d = ST_WAIT; tx_done = 1'b1; end
                     MODE_BIST: state_d = ST_BIST;
                     default:   begin state_d = ST_DATA; byte_req = 1'b1; end
                  endcase
               end else begin
                  state_d = ST_SOP;
               end
            end
            ST_DATA: begin
               // Abort is taken only on a symbol boundary and wins over the byte end.
               if (abort_edge_s) begin
                  state_d   = ST_EOP;
                  cnt_clr_s = 1'b1;
                  tx_abort  = 1'b1;
               end else if (end_s) begin
                  cnt_clr_s = 1'b1;
                  if (bytecnt_q == last_q) begin
                     state_d = ST_CRC;
                  end else begin
                     byte_req  = 1'b1;
                     bytecnt_d = bytecnt_q + PSZ_W'(1);
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_CRC: begin
               if (abort_edge_s) begin
                  state_d   = ST_EOP;
                  cnt_clr_s = 1'b1;
                  tx_abort  = 1'b1;
               end else begin
                  cnt_clr_s = end_s;
                  state_d   = end_s ? ST_EOP : ST_CRC;
               end
            end
            ST_EOP: begin
               cnt_clr_s = end_s;
               state_d   = end_s ? ST_WAIT : ST_EOP;
            end
            ST_WAIT: begin
               cnt_clr_s = end_s;
               state_d   = end_s ? ST_IDLE : ST_WAIT;
               // Cable Reset already reported completion at the end of its ordered set.
               tx_done   = end_s & (mode_q != MODE_CRST);
            end
            ST_BIST: begin
               cnt_clr_s = end_s;
               state_d   = end_s ? ST_IDLE : ST_BIST;
            end
            default: begin
               state_d   = ST_IDLE;
               cnt_clr_s = 1'b1;
            end
         endcase
         if (byte_req & ~byte_vld) begin
            tx_und  = 1'b1;
            abort_d = 1'b1;
         end else begin
            tx_und = 1'b0;
         end
      end
   end

   // Framer state registers.
   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_PKT;
         last_q    <= PSZ_W'(0);
         bytecnt_q <= PSZ_W'(0);
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         last_q    <= last_d;
         bytecnt_q <= bytecnt_d;
         abort_q   <= abort_d;
      end
   end

   assign pre_en  = (state_q == ST_PRE);
   assign sop_en  = (state_q == ST_SOP);
   assign data_en = (state_q == ST_DATA);
   assign crc_en  = (state_q == ST_CRC);
   assign eop_en  = (state_q == ST_EOP);
   assign bist_en = (state_q == ST_BIST);
   assign wait_en = (state_q == ST_WAIT);
   assign cc_oen  = pre_en | sop_en | data_en | crc_en | eop_en | bist_en | wait_en;

endmodule

// File: tb/tb_apb_ucpd_tx_framer.sv
// Bench for the UCPD transmit framer: directed frame table, randomized frames
// against a phase-length model, and enable/reset/drop corner sequences.
module tb_apb_ucpd_tx_framer;

   localparam int PSZ_W = 10;

   logic             ic_clk, ic_rst_n, ucpden, bit_tick, tx_start, transwin_en, hrst_req, byte_vld;
   logic [1:0]       tx_mode;
   logic [PSZ_W-1:0] tx_paysize;
   logic             byte_req, pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en;
   logic             cc_oen, tx_done, tx_abort, tx_und, start_drop;
   logic [12:0]      outs;

   int vec_cnt = 0;
   int miscmp  = 0;

   typedef struct {
      int pre, sop, dat, crc, eop, bist, wt, breq, done, abrt, und, sdrop;
   } res_t;

   typedef struct {
      logic [1:0] mode;
      int         psz, und_k, hph, hb;
      bit         drop;
      res_t       exp;
   } vec_t;

   apb_ucpd_tx_framer dut (
      .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden), .bit_tick(bit_tick),
      .tx_start(tx_start), .tx_mode(tx_mode), .tx_paysize(tx_paysize),
      .transwin_en(transwin_en), .hrst_req(hrst_req), .byte_vld(byte_vld),
      .byte_req(byte_req), .pre_en(pre_en), .sop_en(sop_en), .data_en(data_en),
      .crc_en(crc_en), .eop_en(eop_en), .bist_en(bist_en), .wait_en(wait_en),
      .cc_oen(cc_oen), .tx_done(tx_done), .tx_abort(tx_abort), .tx_und(tx_und),
      .start_drop(start_drop)
   );

   assign outs = {byte_req, pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en,
                  cc_oen, tx_done, tx_abort, tx_und, start_drop};

   always #5 ic_clk = ~ic_clk;

   function automatic res_t mk(input int pre, sop, dat, crc, eop, bist, wt,
                               input int breq, done, abrt, und, sdrop);
      res_t r;
      r.pre = pre; r.sop = sop; r.dat = dat; r.crc = crc; r.eop = eop; r.bist = bist;
      r.wt = wt; r.breq = breq; r.done = done; r.abrt = abrt; r.und = und; r.sdrop = sdrop;
      return r;
   endfunction

   function automatic vec_t mkv(input logic [1:0] m, input int psz, und_k, hph, hb,
                                input bit drop, input res_t e);
      vec_t v;
      v.mode = m; v.psz = psz; v.und_k = und_k; v.hph = hph; v.hb = hb; v.drop = drop; v.exp = e;
      return v;
   endfunction

   // Expected phase lengths / pulse counts of one frame from the framing rules.
   // hph: 0 none, 1 hard-reset request raised in DATA, 2 in CRC, at phase bit hb.
   function automatic res_t model(input logic [1:0] m, input int psz, und_k, hph, hb, input bit drop);
      res_t r;
      int   p, t;
      r = mk(64, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, drop ? 1 : 0);
      case (m)
         2'd1: r.done = 1;
         2'd2: begin r.wt = 25; r.done = 1; end
         2'd3: r.bist = 4096;
         default: begin
            p = (psz < 1) ? 1 : psz;
            r.dat = 10 * p; r.crc = 40; r.eop = 5; r.wt = 25; r.done = 1; r.breq = p;
            t = hb + (4 - hb % 5);   // first symbol boundary at or after hb
            if (und_k >= 1 && und_k <= p) begin
               r.und = 1; r.abrt = 1; r.breq = und_k; r.crc = 0;
               r.dat = 10 * (und_k - 1) + 5;
            end else if (hph == 1) begin
               r.dat = t + 1; r.breq = 1 + t / 10; r.crc = 0; r.abrt = 1;
            end else if (hph == 2) begin
               r.crc = t + 1; r.abrt = 1;
            end
         end
      endcase
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_res(input string tag, input res_t a, input res_t e, input int bad, input int hang);
      chk({tag, ".pre"},   a.pre,   e.pre);
      chk({tag, ".sop"},   a.sop,   e.sop);
      chk({tag, ".data"},  a.dat,   e.dat);
      chk({tag, ".crc"},   a.crc,   e.crc);
      chk({tag, ".eop"},   a.eop,   e.eop);
      chk({tag, ".bist"},  a.bist,  e.bist);
      chk({tag, ".wait"},  a.wt,    e.wt);
      chk({tag, ".breq"},  a.breq,  e.breq);
      chk({tag, ".done"},  a.done,  e.done);
      chk({tag, ".abort"}, a.abrt,  e.abrt);
      chk({tag, ".und"},   a.und,   e.und);
      chk({tag, ".sdrop"}, a.sdrop, e.sdrop);
      chk({tag, ".onehot"}, bad, 0);
      chk({tag, ".timeout"}, hang, 0);
   endtask

   // Start a frame, tick it through with random gaps and tally what the DUT shows.
   task automatic run_frame(input logic [1:0] m, input int psz, und_k, hph, hb, input bit drop,
                            output res_t o, output int bad, output int hang);
      bit seen, dropped, hr;
      o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bad = 0; hang = 1; seen = 1'b0; dropped = 1'b0; hr = 1'b0;
      @(posedge ic_clk); #1;
      tx_mode = m; tx_paysize = psz[PSZ_W-1:0]; transwin_en = 1'b1; tx_start = 1'b1;
      bit_tick = 1'b0; byte_vld = 1'b1; hrst_req = 1'b0;
      @(negedge ic_clk);
      o.sdrop += int'(start_drop);
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(posedge ic_clk); #1;
         tx_start = 1'b0;
         if (drop && !dropped && data_en) begin tx_start = 1'b1; dropped = 1'b1; end
         bit_tick = ($urandom_range(0, 2) != 0);
         byte_vld = !(und_k > 0 && o.breq >= und_k - 1);
         if ((hph == 1 && data_en && o.dat >= hb) || (hph == 2 && crc_en && o.crc >= hb)) hr = 1'b1;
         hrst_req = hr;
         @(negedge ic_clk);
         if (bit_tick) begin
            o.pre  += int'(pre_en);  o.sop  += int'(sop_en);  o.dat += int'(data_en);
            o.crc  += int'(crc_en);  o.eop  += int'(eop_en);  o.bist += int'(bist_en);
            o.wt   += int'(wait_en);
         end
         o.breq  += int'(byte_req); o.done += int'(tx_done); o.abrt += int'(tx_abort);
         o.und   += int'(tx_und);   o.sdrop += int'(start_drop);
         if ($countones({pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en}) > 1 ||
             cc_oen !== (pre_en | sop_en | data_en | crc_en | eop_en | bist_en | wait_en)) bad++;
         if (cc_oen) seen = 1'b1;
         else if (seen) begin hang = 0; break; end
      end
      tx_start = 1'b0; bit_tick = 1'b0; hrst_req = 1'b0; byte_vld = 1'b1;
   endtask

   initial begin
      vec_t tbl[12];
      res_t o, e;
      int   bad, hang, n, psz, und_k, hph, hb, p;
      logic [1:0] m;

      tbl[0]  = mkv(2'd0, 2, 0, 0, 0,  1'b0, mk(64, 20, 20, 40, 5, 0,    25, 2, 1, 0, 0, 0));
      tbl[1]  = mkv(2'd1, 2, 0, 0, 0,  1'b0, mk(64, 20, 0,  0,  0, 0,    0,  0, 1, 0, 0, 0));
      tbl[2]  = mkv(2'd2, 1, 0, 0, 0,  1'b0, mk(64, 20, 0,  0,  0, 0,    25, 0, 1, 0, 0, 0));
      tbl[3]  = mkv(2'd0, 4, 3, 0, 0,  1'b0, mk(64, 20, 25, 0,  5, 0,    25, 3, 1, 1, 1, 0));
      tbl[4]  = mkv(2'd0, 1, 0, 2, 12, 1'b0, mk(64, 20, 10, 15, 5, 0,    25, 1, 1, 1, 0, 0));
      tbl[5]  = mkv(2'd0, 0, 0, 0, 0,  1'b0, mk(64, 20, 10, 40, 5, 0,    25, 1, 1, 0, 0, 0));
      tbl[6]  = mkv(2'd0, 3, 0, 1, 9,  1'b0, mk(64, 20, 10, 0,  5, 0,    25, 1, 1, 1, 0, 0));
      tbl[7]  = mkv(2'd0, 1, 0, 2, 39, 1'b0, mk(64, 20, 10, 40, 5, 0,    25, 1, 1, 1, 0, 0));
      tbl[8]  = mkv(2'd0, 2, 0, 1, 19, 1'b0, mk(64, 20, 20, 0,  5, 0,    25, 2, 1, 1, 0, 0));
      tbl[9]  = mkv(2'd0, 3, 0, 0, 0,  1'b1, mk(64, 20, 30, 40, 5, 0,    25, 3, 1, 0, 0, 1));
      tbl[10] = mkv(2'd0, 2, 1, 0, 0,  1'b0, mk(64, 20, 5,  0,  5, 0,    25, 1, 1, 1, 1, 0));
      tbl[11] = mkv(2'd3, 1, 0, 0, 0,  1'b0, mk(64, 20, 0,  0,  0, 4096, 0,  0, 0, 0, 0, 0));

      ic_clk = 1'b0; ic_rst_n = 1'b0; ucpden = 1'b1; bit_tick = 1'b0; tx_start = 1'b0;
      tx_mode = 2'd0; tx_paysize = '0; transwin_en = 1'b1; hrst_req = 1'b0; byte_vld = 1'b1;

      repeat (3) @(posedge ic_clk);
      @(negedge ic_clk);
      chk("reset_outs", int'(outs), 0);
      @(posedge ic_clk); #1 ic_rst_n = 1'b1;
      @(negedge ic_clk);
      chk("idle_outs", int'(outs), 0);

      for (int i = 0; i < 12; i++) begin
         run_frame(tbl[i].mode, tbl[i].psz, tbl[i].und_k, tbl[i].hph, tbl[i].hb, tbl[i].drop, o, bad, hang);
         chk_res($sformatf("tbl%0d", i), o, tbl[i].exp, bad, hang);
      end

      for (int i = 0; i < 12; i++) begin
         n = $urandom_range(0, 15);
         m = (n < 11) ? 2'd0 : (n < 13) ? 2'd1 : (n < 15) ? 2'd2 : 2'd3;
         psz = $urandom_range(0, 5);
         p = (psz < 1) ? 1 : psz;
         und_k = 0; hph = 0; hb = 0;
         if (m == 2'd0) begin
            hph = $urandom_range(0, 3);
            if (hph == 3) begin hph = 0; und_k = $urandom_range(1, p); end
            else if (hph == 1) hb = $urandom_range(0, 10 * p - 1);
            else if (hph == 2) hb = $urandom_range(0, 39);
         end
         e = model(m, psz, und_k, hph, hb, 1'b0);
         run_frame(m, psz, und_k, hph, hb, 1'b0, o, bad, hang);
         chk_res($sformatf("rnd%0d", i), o, e, bad, hang);
      end

      // Start request with the transmit window closed is dropped.
      @(posedge ic_clk); #1 transwin_en = 1'b0; tx_start = 1'b1;
      @(negedge ic_clk);
      chk("nowin_drop", int'(start_drop), 1);
      @(posedge ic_clk); #1 tx_start = 1'b0; transwin_en = 1'b1;
      @(negedge ic_clk);
      chk("nowin_idle", int'(cc_oen), 0);

      // Block disable in the middle of DATA.
      @(posedge ic_clk); #1 tx_mode = 2'd0; tx_paysize = 10'd4; tx_start = 1'b1;
      @(posedge ic_clk); #1 tx_start = 1'b0; bit_tick = 1'b1;
      n = 0;
      while (!data_en && n < 200) begin @(posedge ic_clk); #1; n++; end
      repeat (3) @(posedge ic_clk);
      #1;
      chk("ucpden_in_data", int'(data_en), 1);
      ucpden = 1'b0;
      @(negedge ic_clk);
      chk("ucpden_pulses", int'({byte_req, tx_done, tx_abort, tx_und, start_drop}), 0);
      @(negedge ic_clk);
      chk("ucpden_idle", int'(outs), 0);
      @(posedge ic_clk); #1 ucpden = 1'b1; bit_tick = 1'b0;
      run_frame(2'd0, 1, 0, 0, 0, 1'b0, o, bad, hang);
      chk_res("after_en", o, model(2'd0, 1, 0, 0, 0, 1'b0), bad, hang);

      // Asynchronous reset in the middle of the preamble.
      @(posedge ic_clk); #1 tx_mode = 2'd0; tx_paysize = 10'd2; tx_start = 1'b1;
      @(posedge ic_clk); #1 tx_start = 1'b0; bit_tick = 1'b1;
      repeat (10) @(posedge ic_clk);
      @(negedge ic_clk);
      chk("pre_mid", int'(pre_en), 1);
      #2 ic_rst_n = 1'b0;
      #1 chk("rst_async", int'(outs), 0);
      @(posedge ic_clk); #1 ic_rst_n = 1'b1; bit_tick = 1'b0;
      @(negedge ic_clk);
      chk("post_rst", int'(outs), 0);
      run_frame(2'd1, 1, 0, 0, 0, 1'b0, o, bad, hang);
      chk_res("after_rst", o, model(2'd1, 1, 0, 0, 0, 1'b0), bad, hang);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule
